// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared types, twiddles, butterfly schedule and bit reversal for fft8_bfly_sched
package fft8_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Q.8 twiddles: W1 = e^{-j*pi/4}, W3 = e^{-j*3pi/4}; 181/256 ~ 0.707
  localparam int W1R = 181;
  localparam int W1I = -181;
  localparam int W3R = -181;
  localparam int W3I = -181;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } sched_t;

  // In-place DIT schedule over bit-reversed storage: 3 stages x 4 butterflies
  function automatic sched_t sched_entry(input logic [3:0] step);
    case (step)
      4'd0:    sched_entry = '{a: 3'd0, b: 3'd1, tw: 2'd0};
      4'd1:    sched_entry = '{a: 3'd2, b: 3'd3, tw: 2'd0};
      4'd2:    sched_entry = '{a: 3'd4, b: 3'd5, tw: 2'd0};
      4'd3:    sched_entry = '{a: 3'd6, b: 3'd7, tw: 2'd0};
      4'd4:    sched_entry = '{a: 3'd0, b: 3'd2, tw: 2'd0};
      4'd5:    sched_entry = '{a: 3'd1, b: 3'd3, tw: 2'd2};
      4'd6:    sched_entry = '{a: 3'd4, b: 3'd6, tw: 2'd0};
      4'd7:    sched_entry = '{a: 3'd5, b: 3'd7, tw: 2'd2};
      4'd8:    sched_entry = '{a: 3'd0, b: 3'd4, tw: 2'd0};
      4'd9:    sched_entry = '{a: 3'd1, b: 3'd5, tw: 2'd1};
      4'd10:   sched_entry = '{a: 3'd2, b: 3'd6, tw: 2'd2};
      4'd11:   sched_entry = '{a: 3'd3, b: 3'd7, tw: 2'd3};
      default: sched_entry = '{a: 3'd0, b: 3'd0, tw: 2'd0};
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    bitrev3 = {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_cbfly.sv
// rtl/fft8_cbfly.sv - combinational radix-2 complex butterfly with W8^0..W8^3 twiddle
module fft8_cbfly
  import fft8_pkg::*;
#(
  parameter int W       = 9,
  parameter int TW_FRAC = 8
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic [1:0]          tw,
  output logic signed [W-1:0] ap_re,
  output logic signed [W-1:0] ap_im,
  output logic signed [W-1:0] bp_re,
  output logic signed [W-1:0] bp_im
);

  localparam int PW = 2 * W;
  localparam logic signed [W-1:0] C1R = W'(W1R);
  localparam logic signed [W-1:0] C1I = W'(W1I);
  localparam logic signed [W-1:0] C3R = W'(W3R);
  localparam logic signed [W-1:0] C3I = W'(W3I);

  logic signed [W-1:0]  wr, wi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   s_re, s_im, sh_re, sh_im;
  logic signed [W-1:0]  t_re, t_im;
  logic                 unused_hi;

  // Full-width products for the two non-trivial twiddles; only W1/W3 use them
  assign wr    = (tw == 2'd3) ? C3R : C1R;
  assign wi    = (tw == 2'd3) ? C3I : C1I;
  assign p_rr  = PW'(wr) * PW'(b_re);
  assign p_ii  = PW'(wi) * PW'(b_im);
  assign p_ri  = PW'(wr) * PW'(b_im);
  assign p_ir  = PW'(wi) * PW'(b_re);
  assign s_re  = (PW+1)'(p_rr) - (PW+1)'(p_ii);
  assign s_im  = (PW+1)'(p_ri) + (PW+1)'(p_ir);
  assign sh_re = s_re >>> TW_FRAC;
  assign sh_im = s_im >>> TW_FRAC;
  assign unused_hi = ^{sh_re[PW:W], sh_im[PW:W]};

  // Twiddle select: W0 bypasses, W2 is an exact rotation by -j, W1/W3 are scaled products
  always_comb begin
    t_re = b_re;
    t_im = b_im;
    case (tw)
      2'd0: begin
        t_re = b_re;
        t_im = b_im;
      end
      2'd2: begin
        t_re = b_im;
        t_im = -b_re;
      end
      default: begin
        t_re = sh_re[W-1:0];
        t_im = sh_im[W-1:0];
      end
    endcase
  end

  assign ap_re = a_re + t_re;
  assign ap_im = a_im + t_im;
  assign bp_re = a_re - t_re;
  assign bp_im = a_im - t_im;

endmodule

// File: rtl/fft8_bfly_sched.sv
// rtl/fft8_bfly_sched.sv - sequenced 8-point DIT FFT sharing one butterfly across 12 operations
module fft8_bfly_sched
  import fft8_pkg::*;
#(
  parameter int W       = 9,
  parameter int TW_FRAC = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [2:0]   out_idx,
  output logic         busy,
  output logic         frame_done
);

  state_t              state, state_nx;
  logic [2:0]          ld_cnt;
  logic [3:0]          step;
  logic [2:0]          k;
  logic signed [W-1:0] mem_re [8];
  logic signed [W-1:0] mem_im [8];
  sched_t              cur;
  logic signed [W-1:0] ap_re, ap_im, bp_re, bp_im;
  logic                in_hs, out_hs;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign out_idx   = k;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign cur       = sched_entry(step);

  fft8_cbfly #(.W(W), .TW_FRAC(TW_FRAC)) u_bfly (
    .a_re  (mem_re[cur.a]),
    .a_im  (mem_im[cur.a]),
    .b_re  (mem_re[cur.b]),
    .b_im  (mem_im[cur.b]),
    .tw    (cur.tw),
    .ap_re (ap_re),
    .ap_im (ap_im),
    .bp_re (bp_re),
    .bp_im (bp_im)
  );

  // Next-state: 8 accepts, 12 butterflies, 8 output handshakes
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_hs && ld_cnt == 3'd7) state_nx = CALC;
      CALC:    if (step == 4'd11) state_nx = DRAIN;
      DRAIN:   if (out_hs && k == 3'd7) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LOAD;
    else       state <= state_nx;
  end

  // Sequencing counters and end-of-frame pulse; each counter wraps to 0 at the end of its phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt     <= '0;
      step       <= '0;
      k          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && (k == 3'd7);
      if (in_hs) ld_cnt <= ld_cnt + 3'd1;
      if (state == CALC) step <= (step == 4'd11) ? 4'd0 : step + 4'd1;
      if (out_hs) k <= k + 3'd1;
    end
  end

  // Register file: bit-reversed load, then in-place butterfly write-back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else if (in_hs) begin
      mem_re[bitrev3(ld_cnt)] <= in_re;
      mem_im[bitrev3(ld_cnt)] <= in_im;
    end else if (state == CALC) begin
      mem_re[cur.a] <= ap_re;
      mem_im[cur.a] <= ap_im;
      mem_re[cur.b] <= bp_re;
      mem_im[cur.b] <= bp_im;
    end
  end

  // Output bin register: bin 0 is final after stage 2's first butterfly, so it is preloaded on the last CALC cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_re <= '0;
      out_im <= '0;
    end else if (state == CALC && step == 4'd11) begin
      out_re <= mem_re[0];
      out_im <= mem_im[0];
    end else if (out_hs && k != 3'd7) begin
      out_re <= mem_re[k + 3'd1];
      out_im <= mem_im[k + 3'd1];
    end
  end

endmodule
